// File: rtl/mem_arbiter_pkg.sv
// Shared state encodings and client identifiers for the backing-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_state_t;

  localparam logic ARB_CLIENT_I = 1'b0;
  localparam logic ARB_CLIENT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-input request picker. Fixed dcache priority by default; round-robin on contention
// when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic v0,
  input  logic v1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic win,
  output logic any
);

  always_comb begin
    any = v0 | v1;
    win = v1 ? ARB_CLIENT_D : ARB_CLIENT_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention, hand the port to whoever did not win last time.
    if (v0 && v1)
      win = ~last_grant;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between icache (client 0) and dcache (client 1).
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin grant on contention).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int BEATS     = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   c0_req_valid,
  output logic                   c0_req_ready,
  input  logic [ADDR_BITS-1:0]   c0_req_addr,
  input  logic                   c0_req_rw,
  input  logic                   c0_req_data_valid,
  output logic                   c0_req_data_ready,
  input  logic [DATA_BITS-1:0]   c0_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c0_req_data_mask,
  output logic                   c0_resp_valid,
  output logic [DATA_BITS-1:0]   c0_resp_data,

  input  logic                   c1_req_valid,
  output logic                   c1_req_ready,
  input  logic [ADDR_BITS-1:0]   c1_req_addr,
  input  logic                   c1_req_rw,
  input  logic                   c1_req_data_valid,
  output logic                   c1_req_data_ready,
  input  logic [DATA_BITS-1:0]   c1_req_data_bits,
  input  logic [DATA_BITS/8-1:0] c1_req_data_mask,
  output logic                   c1_resp_valid,
  output logic [DATA_BITS-1:0]   c1_resp_data,

  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int CNT_W  = $clog2(BEATS) + 1;
  localparam int MASK_W = DATA_BITS / 8;

  arb_state_t       state;
  logic             owner;
  logic [CNT_W-1:0] beat_cnt;
  logic             win;
  logic             any;
  logic             sel;

  logic [1:0]           req_valid;
  logic [1:0]           req_rw;
  logic [1:0]           data_valid;
  logic [ADDR_BITS-1:0] req_addr  [2];
  logic [DATA_BITS-1:0] data_bits [2];
  logic [MASK_W-1:0]    data_mask [2];

  logic [1:0] req_ready;
  logic [1:0] data_ready;
  logic [1:0] resp_valid;

  assign req_valid    = {c1_req_valid, c0_req_valid};
  assign req_rw       = {c1_req_rw, c0_req_rw};
  assign data_valid   = {c1_req_data_valid, c0_req_data_valid};
  assign req_addr[0]  = c0_req_addr;
  assign req_addr[1]  = c1_req_addr;
  assign data_bits[0] = c0_req_data_bits;
  assign data_bits[1] = c1_req_data_bits;
  assign data_mask[0] = c0_req_data_mask;
  assign data_mask[1] = c1_req_data_mask;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  mem_arb_pick u_pick (
    .v0         (c0_req_valid),
    .v1         (c1_req_valid),
    .last_grant (last_grant),
    .win        (win),
    .any        (any)
  );
`else
  mem_arb_pick u_pick (
    .v0  (c0_req_valid),
    .v1  (c1_req_valid),
    .win (win),
    .any (any)
  );
`endif

  // While a transaction is in flight the owner keeps the port regardless of its valid.
  assign sel = (state == ARB_IDLE) ? win : owner;

  // Reset gates every output so the port goes quiet the moment reset falls.
  always_comb begin
    mem_req_valid      = 1'b0;
    mem_req_addr       = '0;
    mem_req_rw         = 1'b0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    req_ready          = 2'b00;
    data_ready         = 2'b00;
    resp_valid         = 2'b00;
    c0_resp_data       = '0;
    c1_resp_data       = '0;
    if (reset) begin
      c0_resp_data = mem_resp_data;
      c1_resp_data = mem_resp_data;
      case (state)
        ARB_IDLE: begin
          if (any) begin
            mem_req_valid      = req_valid[sel];
            mem_req_addr       = req_addr[sel];
            mem_req_rw         = req_rw[sel];
            mem_req_data_valid = data_valid[sel];
            mem_req_data_bits  = data_bits[sel];
            mem_req_data_mask  = data_mask[sel];
            req_ready[sel]     = mem_req_ready;
            data_ready[sel]    = mem_req_data_ready;
          end
        end
        ARB_READ: begin
          mem_req_valid   = req_valid[sel];
          mem_req_addr    = req_addr[sel];
          mem_req_rw      = req_rw[sel];
          req_ready[sel]  = mem_req_ready;
          resp_valid[sel] = mem_resp_valid;
        end
        ARB_WRITE: begin
          mem_req_addr       = req_addr[sel];
          mem_req_rw         = 1'b1;
          mem_req_data_valid = data_valid[sel];
          mem_req_data_bits  = data_bits[sel];
          mem_req_data_mask  = data_mask[sel];
          data_ready[sel]    = mem_req_data_ready;
        end
        default: ;
      endcase
    end
  end

  assign c0_req_ready      = req_ready[0];
  assign c1_req_ready      = req_ready[1];
  assign c0_req_data_ready = data_ready[0];
  assign c1_req_data_ready = data_ready[1];
  assign c0_resp_valid     = resp_valid[0];
  assign c1_resp_valid     = resp_valid[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB_IDLE;
      owner    <= ARB_CLIENT_I;
      beat_cnt <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= ARB_CLIENT_D;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (mem_req_valid && mem_req_ready) begin
            owner <= sel;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= sel;
`endif
            if (!mem_req_rw) begin
              state    <= ARB_READ;
              beat_cnt <= '0;
            end else if (!(mem_req_data_valid && mem_req_data_ready)) begin
              state <= ARB_WRITE;
            end
          end
        end
        ARB_READ: begin
          if (mem_resp_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_W'(BEATS - 1))
              state <= ARB_IDLE;
          end
        end
        ARB_WRITE: begin
          if (mem_req_data_valid && mem_req_data_ready)
            state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, contention, masked write, stray responses, mid-burst reset.
module tb_mem_arbiter;

  localparam int AB = 28;
  localparam int DB = 128;
  localparam int MB = DB / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_req_valid, c0_req_ready, c0_req_rw, c0_req_data_valid, c0_req_data_ready;
  logic [AB-1:0] c0_req_addr;
  logic [DB-1:0] c0_req_data_bits, c0_resp_data;
  logic [MB-1:0] c0_req_data_mask;
  logic          c0_resp_valid;
  logic          c1_req_valid, c1_req_ready, c1_req_rw, c1_req_data_valid, c1_req_data_ready;
  logic [AB-1:0] c1_req_addr;
  logic [DB-1:0] c1_req_data_bits, c1_resp_data;
  logic [MB-1:0] c1_req_data_mask;
  logic          c1_resp_valid;
  logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic [AB-1:0] mem_req_addr;
  logic [DB-1:0] mem_req_data_bits, mem_resp_data;
  logic [MB-1:0] mem_req_data_mask;
  logic          mem_resp_valid;

  logic [1:0] rdy_v, drdy_v, resp_v;
  assign rdy_v  = {c1_req_ready, c0_req_ready};
  assign drdy_v = {c1_req_data_ready, c0_req_data_ready};
  assign resp_v = {c1_resp_valid, c0_resp_valid};

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_addr(c0_req_addr),
    .c0_req_rw(c0_req_rw), .c0_req_data_valid(c0_req_data_valid),
    .c0_req_data_ready(c0_req_data_ready), .c0_req_data_bits(c0_req_data_bits),
    .c0_req_data_mask(c0_req_data_mask), .c0_resp_valid(c0_resp_valid),
    .c0_resp_data(c0_resp_data),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_addr(c1_req_addr),
    .c1_req_rw(c1_req_rw), .c1_req_data_valid(c1_req_data_valid),
    .c1_req_data_ready(c1_req_data_ready), .c1_req_data_bits(c1_req_data_bits),
    .c1_req_data_mask(c1_req_data_mask), .c1_resp_valid(c1_resp_valid),
    .c1_resp_data(c1_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one read beat from memory, check routing, then advance one cycle.
  task automatic beat(input logic own, input logic [127:0] d, input string tag);
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    #1;
    chk({tag, "_rv"}, resp_v, own ? 2'b10 : 2'b01);
    chk({tag, "_rd"}, own ? c1_resp_data : c0_resp_data, d);
    tick();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w, l;
    logic [AB-1:0] wa, la;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    w = 1'b0;
`else
    w = 1'b1;
`endif
    l  = ~w;
    wa = w ? 28'h200 : 28'h100;
    la = l ? 28'h200 : 28'h100;

    reset = 1'b0;
    {c0_req_valid, c0_req_rw, c0_req_data_valid} = '0;
    {c1_req_valid, c1_req_rw, c1_req_data_valid} = '0;
    c0_req_addr = '0; c1_req_addr = '0;
    c0_req_data_bits = '0; c1_req_data_bits = '0;
    c0_req_data_mask = '0; c1_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;

    // Reset: outputs forced quiet even with live inputs.
    c0_req_valid = 1'b1; c0_req_addr = 28'h5;
    mem_resp_valid = 1'b1; mem_resp_data = 128'hABCD;
    #3;
    chk("rst_mvld", mem_req_valid, 1'b0);
    chk("rst_rdy", rdy_v, 2'b00);
    chk("rst_resp", resp_v, 2'b00);
    chk("rst_addr", mem_req_addr, 28'h0);
    chk("rst_rdata", c0_resp_data, 128'h0);
    tick(); tick();
    reset = 1'b1;
    c0_req_valid = 1'b0; c0_req_addr = '0; mem_resp_valid = 1'b0;
    tick();

    // Contention: both read in the same cycle.
    c0_req_valid = 1'b1; c0_req_addr = 28'h100;
    c1_req_valid = 1'b1; c1_req_addr = 28'h200;
    #1;
    chk("t2_addr", mem_req_addr, wa);
    chk("t2_rdy", rdy_v, w ? 2'b10 : 2'b01);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        if (w) c1_req_valid = 1'b0; else c0_req_valid = 1'b0;
      end
      #1;
      chk($sformatf("t4_lose_rdy%0d", i), rdy_v[l], 1'b0);
      beat(w, 128'h1000 + 128'(i), $sformatf("t2_wb%0d", i));
    end
    #1;
    chk("t2_next_addr", mem_req_addr, la);
    chk("t2_next_rdy", rdy_v, l ? 2'b10 : 2'b01);
    tick();
    if (l) c1_req_valid = 1'b0; else c0_req_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      beat(l, 128'h2000 + 128'(i), $sformatf("t2_lb%0d", i));

    // Single read from icache.
    c0_req_valid = 1'b1; c0_req_addr = 28'h0000010;
    #1;
    chk("t1_vld", mem_req_valid, 1'b1);
    chk("t1_addr", mem_req_addr, 28'h0000010);
    chk("t1_rdy", rdy_v, 2'b01);
    tick();
    c0_req_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      beat(1'b0, 128'h3000 + 128'(i), $sformatf("t1_b%0d", i));

    // Stray response in IDLE is dropped.
    mem_resp_valid = 1'b1; mem_resp_data = 128'hBAD;
    #1;
    chk("t5_stray", resp_v, 2'b00);
    mem_resp_valid = 1'b0;
    tick();

    // Masked dcache write with delayed data acceptance.
    c1_req_valid = 1'b1; c1_req_rw = 1'b1; c1_req_addr = 28'h0000020;
    c1_req_data_valid = 1'b1; c1_req_data_bits = 128'hDEADBEEF; c1_req_data_mask = 16'h000F;
    #1;
    chk("t3_vld", mem_req_valid, 1'b1);
    chk("t3_rw", mem_req_rw, 1'b1);
    chk("t3_rdy", rdy_v, 2'b10);
    chk("t3_drdy0", drdy_v, 2'b00);
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) mem_req_data_ready = 1'b1;
      mem_resp_valid = 1'b1;
      #1;
      chk($sformatf("t3_wvld%0d", c), mem_req_valid, 1'b0);
      chk($sformatf("t3_dvld%0d", c), mem_req_data_valid, 1'b1);
      chk($sformatf("t3_bits%0d", c), mem_req_data_bits, 128'hDEADBEEF);
      chk($sformatf("t3_mask%0d", c), mem_req_data_mask, 16'h000F);
      chk($sformatf("t3_drdy%0d", c), drdy_v, (c == 3) ? 2'b10 : 2'b00);
      chk($sformatf("t3_wresp%0d", c), resp_v, 2'b00);
      tick();
    end
    mem_resp_valid = 1'b0;
    c1_req_valid = 1'b0; c1_req_rw = 1'b0; c1_req_data_valid = 1'b0;
    mem_req_data_ready = 1'b0;

    // Back in IDLE: icache read granted at once, then reset after beat 2.
    c0_req_valid = 1'b1; c0_req_addr = 28'h30;
    #1;
    chk("t3_idle_rdy", rdy_v, 2'b01);
    tick();
    c0_req_valid = 1'b0;
    beat(1'b0, 128'h4000, "t6_b0");
    beat(1'b0, 128'h4001, "t6_b1");
    reset = 1'b0;
    c0_req_valid = 1'b1; mem_resp_valid = 1'b1;
    #1;
    chk("t6_resp", resp_v, 2'b00);
    chk("t6_mvld", mem_req_valid, 1'b0);
    chk("t6_rdy", rdy_v, 2'b00);
    tick();
    reset = 1'b1; mem_resp_valid = 1'b0; c0_req_addr = 28'h40;
    #1;
    chk("t6_grant", rdy_v, 2'b01);
    tick();
    c0_req_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      beat(1'b0, 128'h5000 + 128'(i), $sformatf("t6_fb%0d", i));
    mem_resp_valid = 1'b1;
    #1;
    chk("t6_after", resp_v, 2'b00);
    mem_resp_valid = 1'b0;
    tick();

    // Write whose data completes with the request stays IDLE; next request granted next cycle.
    c0_req_valid = 1'b1; c0_req_rw = 1'b1; c0_req_data_valid = 1'b1;
    c0_req_data_bits = 128'h55; c0_req_data_mask = 16'hFFFF; mem_req_data_ready = 1'b1;
    #1;
    chk("t7_drdy", drdy_v, 2'b01);
    tick();
    c0_req_valid = 1'b0; c0_req_rw = 1'b0; c0_req_data_valid = 1'b0;
    mem_req_data_ready = 1'b0;
    c1_req_valid = 1'b1; c1_req_addr = 28'h60;
    #1;
    chk("t7_next_rdy", rdy_v, 2'b10);
    chk("t7_next_addr", mem_req_addr, 28'h60);
    tick();
    c1_req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
